// File: rtl/demux1_4_buf.sv
// demux1_4_buf -- 1-to-4 demultiplexer with a small FIFO behind each output.
//
// A word presented on in_data/Sel with in_valid is steered into the FIFO of
// channel Sel (0=A, 1=B, 2=C, 3=D) when in_ready is high. Each channel drains
// independently through its own out_valid/out_ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    [WIDTH] word to route
//   Sel        [2]     destination channel, sampled with in_data
//   in_valid   input word valid
//   in_ready   the channel addressed by Sel has room (combinational on Sel)
//   A_out..D_out [WIDTH] head-of-FIFO word per channel, 0 while empty
//   out_valid  [4]     per-channel head valid
//   out_ready  [4]     per-channel consumer takes the head
//   acc_count  [8]     words accepted since reset, modulo 256

// Per-channel FIFO. Pointers are AW bits wide so they wrap modulo DEPTH
// for free; DEPTH must be a power of two.
module demux1_4_buf_lane #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_valid = (r_cnt != '0);
  // Empty lane drives 0 so the output is deterministic rather than stale.
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;

  // A full lane refuses a push even when it is popped on the same edge.
  assign w_wr = i_push & ~o_full;
  assign w_rd = i_pop  & o_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module demux1_4_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [WIDTH-1:0] C_out,
  output logic [WIDTH-1:0] D_out,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       acc_count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            w_push;
  logic [NUM_LANES-1:0]            w_pop;
  logic [NUM_LANES-1:0]            w_full;
  logic [NUM_LANES-1:0]            w_valid;
  logic [NUM_LANES-1:0][WIDTH-1:0] w_head;
  logic                            w_accept;
  logic [7:0]                      r_acc_cnt;

  // Readiness looks only at the addressed lane, so a stalled channel never
  // blocks traffic bound elsewhere.
  assign in_ready = ~w_full[Sel];
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_push[g] = w_accept & (Sel == 2'(g));
      assign w_pop[g]  = out_ready[g] & w_valid[g];

      demux1_4_buf_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push[g]),
        .i_pop  (w_pop[g]),
        .i_data (in_data),
        .o_data (w_head[g]),
        .o_valid(w_valid[g]),
        .o_full (w_full[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)           r_acc_cnt <= '0;
    else if (w_accept) r_acc_cnt <= r_acc_cnt + 8'd1;
  end

  assign out_valid = w_valid;
  assign A_out     = w_head[0];
  assign B_out     = w_head[1];
  assign C_out     = w_head[2];
  assign D_out     = w_head[3];
  assign acc_count = r_acc_cnt;
endmodule

// File: tb/tb_demux1_4_buf.sv
// Bench for demux1_4_buf: a table of directed vectors with constant
// expectations, a per-channel scoreboard queue checking every head word,
// a mid-operation reset sequence and a 256-word wrap run.
module tb_demux1_4_buf;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       Sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A_out, B_out, C_out, D_out;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [7:0]       acc_count;

  demux1_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .Sel(Sel), .in_valid(in_valid),
    .in_ready(in_ready), .A_out(A_out), .B_out(B_out), .C_out(C_out),
    .D_out(D_out), .out_valid(out_valid), .out_ready(out_ready),
    .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] dout [4];
  assign dout[0] = A_out;
  assign dout[1] = B_out;
  assign dout[2] = C_out;
  assign dout[3] = D_out;

  // Scoreboard: one expected-word queue per channel plus an accept counter.
  logic [WIDTH-1:0] q [4][$];
  logic [7:0]       m_acc;
  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [1:0]       sel;
    logic [WIDTH-1:0] d;
    logic             v;
    logic [3:0]       ordy;
    logic             rdy;   // in_ready before the edge
    logic [3:0]       ov;    // out_valid after the edge
    logic [7:0]       acc;   // acc_count after the edge
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) q[i].delete();
    m_acc = 8'd0;
  endtask

  // Compare every output against the scoreboard.
  task automatic check_outputs(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s out_valid[%0d]", tag, i), int'(out_valid[i]),
          (q[i].size() > 0) ? 1 : 0);
      if (q[i].size() > 0)
        chk($sformatf("%s head[%0d]", tag, i), int'(dout[i]), int'(q[i][0]));
    end
    chk({tag, " acc_count"}, int'(acc_count), int'(m_acc));
  endtask

  // One cycle: drive inputs, check in_ready, update the model for the edge,
  // then check outputs after the edge.
  task automatic step(input logic [1:0] s, input logic [WIDTH-1:0] d,
                      input logic v, input logic [3:0] ordy,
                      output logic rdy_seen);
    logic exp_rdy;
    Sel = s; in_data = d; in_valid = v; out_ready = ordy;
    #1;
    exp_rdy  = (q[s].size() < DEPTH);
    rdy_seen = in_ready;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    for (int i = 0; i < 4; i++)
      if (ordy[i] && q[i].size() > 0) void'(q[i].pop_front());
    if (v && exp_rdy) begin
      q[s].push_back(d);
      m_acc = m_acc + 8'd1;
    end
    @(posedge clk); #1;
    check_outputs("step");
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; Sel = 2'd0; in_data = 4'hF; out_ready = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    clear_model();
  endtask

  initial begin
    logic r;
    logic [1:0] s;
    logic [WIDTH-1:0] d;

    //            sel   d  v  ordy     rdy  ov       acc
    tbl[0]  = '{2'd0, 4'd1, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'd1};
    tbl[1]  = '{2'd0, 4'd2, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'd2};
    tbl[2]  = '{2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'b0001, 8'd2};
    tbl[3]  = '{2'd1, 4'd3, 1'b1, 4'b0000, 1'b1, 4'b0011, 8'd3};
    tbl[4]  = '{2'd2, 4'd4, 1'b1, 4'b0000, 1'b1, 4'b0111, 8'd4};
    tbl[5]  = '{2'd2, 4'd5, 1'b1, 4'b0000, 1'b1, 4'b0111, 8'd5};
    tbl[6]  = '{2'd2, 4'd0, 1'b0, 4'b0100, 1'b0, 4'b0111, 8'd5};
    tbl[7]  = '{2'd2, 4'd0, 1'b0, 4'b0100, 1'b1, 4'b0011, 8'd5};
    tbl[8]  = '{2'd3, 4'd6, 1'b1, 4'b0000, 1'b1, 4'b1011, 8'd6};
    tbl[9]  = '{2'd3, 4'd7, 1'b1, 4'b1000, 1'b1, 4'b1011, 8'd7};
    tbl[10] = '{2'd3, 4'd8, 1'b1, 4'b0000, 1'b1, 4'b1011, 8'd8};
    tbl[11] = '{2'd3, 4'd9, 1'b1, 4'b1000, 1'b0, 4'b1011, 8'd8};
    tbl[12] = '{2'd3, 4'd0, 1'b0, 4'b1000, 1'b1, 4'b0011, 8'd8};
    tbl[13] = '{2'd2, 4'd0, 1'b0, 4'b0100, 1'b1, 4'b0011, 8'd8};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; Sel = 2'd0; out_ready = 4'h0;
    clear_model();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    // Idle after reset: everything empty and zero, every channel ready.
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset acc_count", int'(acc_count), 0);
    for (int i = 0; i < 4; i++) chk("reset data", int'(dout[i]), 0);
    for (int i = 0; i < 4; i++) begin
      Sel = 2'(i); #1;
      chk("reset in_ready", int'(in_ready), 1);
    end

    // Directed vectors with fixed expectations.
    for (int k = 0; k < 14; k++) begin
      step(tbl[k].sel, tbl[k].d, tbl[k].v, tbl[k].ordy, r);
      chk($sformatf("tbl%0d in_ready", k), int'(r), int'(tbl[k].rdy));
      chk($sformatf("tbl%0d out_valid", k), int'(out_valid), int'(tbl[k].ov));
      chk($sformatf("tbl%0d acc_count", k), int'(acc_count), int'(tbl[k].acc));
    end
    chk("D head after replace", int'(D_out), 0);   // D drained in tbl[12]
    chk("B held", int'(B_out), 3);

    // Mid-operation reset: fill A and B, reset, buffered words must vanish.
    step(2'd0, 4'd10, 1'b1, 4'b0000, r);
    step(2'd0, 4'd11, 1'b1, 4'b0000, r);
    step(2'd1, 4'd12, 1'b1, 4'b0000, r);
    chk("pre-reset out_valid", int'(out_valid), 4'b0011);
    do_reset();
    chk("post-reset out_valid", int'(out_valid), 0);
    chk("post-reset acc_count", int'(acc_count), 0);
    for (int i = 0; i < 4; i++) chk("post-reset data", int'(dout[i]), 0);
    for (int i = 0; i < 4; i++) begin
      Sel = 2'(i); #1;
      chk("post-reset in_ready", int'(in_ready), 1);
    end
    step(2'd0, 4'd13, 1'b1, 4'b0000, r);
    chk("A new word", int'(A_out), 13);
    step(2'd0, 4'd0, 1'b0, 4'b0001, r);
    chk("A drained", int'(out_valid[0]), 0);
    step(2'd1, 4'd0, 1'b0, 4'b0000, r);
    chk("B stays empty", int'(out_valid[1]), 0);

    // 256 words spread across channels with all consumers ready.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      s = 2'($urandom_range(0, 3));
      d = WIDTH'($urandom);
      step(s, d, 1'b1, 4'hF, r);
    end
    chk("wrap acc_count", int'(acc_count), 0);
    repeat (2) step(2'd0, 4'd0, 1'b0, 4'hF, r);
    chk("drained out_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++)
      chk("scoreboard empty", q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
